// File: rtl/alarm_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// alarm_sequencer : one-shot alarm event from comparator match, with blinking
//                   LEDs, snooze, dismiss and auto-timeout.   Rev 1.0
// -----------------------------------------------------------------------------
module alarm_sequencer #(
  parameter int BLINK_DIV    = 50000000,
  parameter int SNOOZE_SECS  = 300,
  parameter int TIMEOUT_SECS = 60,
  parameter int MAX_SNOOZES  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] flash_in,
  input  logic        tick_1hz,
  input  logic        enable,
  input  logic        dismiss,
  input  logic        snooze,
  output logic [15:0] leds,
  output logic        ringing,
  output logic        snoozing
);

  localparam int c_blink_w  = $clog2(BLINK_DIV + 1);
  localparam int c_ring_w   = $clog2(TIMEOUT_SECS + 1);
  localparam int c_snzsec_w = $clog2(SNOOZE_SECS + 1);
  localparam int c_snzcnt_w = $clog2(MAX_SNOOZES + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    match_dly_q, match_dly_d;
  logic [c_blink_w-1:0]    blink_cnt_q, blink_cnt_d;
  logic                    phase_on_q, phase_on_d;
  logic [c_ring_w-1:0]     ring_secs_q, ring_secs_d;
  logic [c_snzsec_w-1:0]   snooze_secs_q, snooze_secs_d;
  logic [c_snzcnt_w-1:0]   snooze_cnt_q, snooze_cnt_d;
  logic [15:0]             leds_q, leds_d;

  logic match;
  logic rise;

  assign match = |flash_in;
  assign rise  = match & ~match_dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      match_dly_q   <= 1'b0;
      blink_cnt_q   <= '0;
      phase_on_q    <= 1'b0;
      ring_secs_q   <= '0;
      snooze_secs_q <= '0;
      snooze_cnt_q  <= '0;
      leds_q        <= 16'h0000;
    end else begin
      state_q       <= state_d;
      match_dly_q   <= match_dly_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_on_q    <= phase_on_d;
      ring_secs_q   <= ring_secs_d;
      snooze_secs_q <= snooze_secs_d;
      snooze_cnt_q  <= snooze_cnt_d;
      leds_q        <= leds_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    match_dly_d   = match;
    blink_cnt_d   = blink_cnt_q;
    phase_on_d    = phase_on_q;
    ring_secs_d   = ring_secs_q;
    snooze_secs_d = snooze_secs_q;
    snooze_cnt_d  = snooze_cnt_q;

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d      = ST_RINGING;
            ring_secs_d  = '0;
            blink_cnt_d  = '0;
            phase_on_d   = 1'b1;
            snooze_cnt_d = '0;
          end
        end
        ST_RINGING: begin
          if (dismiss) begin
            state_d = ST_DONE;
          end else if (snooze && (snooze_cnt_q < c_snzcnt_w'(MAX_SNOOZES))) begin
            state_d       = ST_SNOOZE;
            snooze_secs_d = c_snzsec_w'(SNOOZE_SECS);
            snooze_cnt_d  = snooze_cnt_q + c_snzcnt_w'(1);
          end else begin
            if (blink_cnt_q == c_blink_w'(BLINK_DIV - 1)) begin
              blink_cnt_d = '0;
              phase_on_d  = ~phase_on_q;
            end else begin
              blink_cnt_d = blink_cnt_q + c_blink_w'(1);
            end
            if (tick_1hz) begin
              if (ring_secs_q == c_ring_w'(TIMEOUT_SECS - 1)) begin
                state_d = ST_DONE;
              end else begin
                ring_secs_d = ring_secs_q + c_ring_w'(1);
              end
            end
          end
        end
        ST_SNOOZE: begin
          if (dismiss) begin
            state_d = ST_DONE;
          end else if (tick_1hz) begin
            if (snooze_secs_q == c_snzsec_w'(1)) begin
              state_d     = ST_RINGING;
              ring_secs_d = '0;
              blink_cnt_d = '0;
              phase_on_d  = 1'b1;
            end else begin
              snooze_secs_d = snooze_secs_q - c_snzsec_w'(1);
            end
          end
        end
        ST_DONE: begin
          // Hold off until the matching minute ends so the same match cannot re-ring.
          if (!match) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    leds_d = ((state_d == ST_RINGING) && phase_on_d) ? 16'hFFFF : 16'h0000;
  end

  assign leds     = leds_q;
  assign ringing  = (state_q == ST_RINGING);
  assign snoozing = (state_q == ST_SNOOZE);

endmodule
`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_alarm_sequencer : directed + randomized bench against an event-level model.
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_alarm_sequencer;

  localparam int BLINK_DIV    = 4;
  localparam int SNOOZE_SECS  = 3;
  localparam int TIMEOUT_SECS = 5;
  localparam int MAX_SNOOZES  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] flash_in = 16'h0;
  logic        tick_1hz = 1'b0;
  logic        enable = 1'b0;
  logic        dismiss = 1'b0;
  logic        snooze = 1'b0;
  logic [15:0] leds;
  logic        ringing;
  logic        snoozing;

  alarm_sequencer #(
    .BLINK_DIV   (BLINK_DIV),
    .SNOOZE_SECS (SNOOZE_SECS),
    .TIMEOUT_SECS(TIMEOUT_SECS),
    .MAX_SNOOZES (MAX_SNOOZES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flash_in(flash_in),
    .tick_1hz(tick_1hz),
    .enable  (enable),
    .dismiss (dismiss),
    .snooze  (snooze),
    .leds    (leds),
    .ringing (ringing),
    .snoozing(snoozing)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
  endtask

  // Event-level model: 0 idle, 1 ringing, 2 snoozed, 3 done.
  int m_mode = 0;
  bit m_prev_match = 0;
  int m_ring_age = 0;      // cycles spent ringing since (re)entry
  int m_ring_ticks = 0;    // seconds heard while ringing since (re)entry
  int m_snooze_left = 0;   // seconds remaining in the current snooze
  int m_snoozes_used = 0;

  task automatic model_step();
    bit m;
    m = (flash_in != 16'h0);
    if (rst) begin
      m_mode = 0; m_prev_match = 0; m_ring_age = 0; m_ring_ticks = 0;
      m_snooze_left = 0; m_snoozes_used = 0;
      return;
    end
    if (!enable) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (m && !m_prev_match) begin
             m_mode = 1; m_ring_age = 0; m_ring_ticks = 0; m_snoozes_used = 0;
           end
        1: if (dismiss) m_mode = 3;
           else if (snooze && m_snoozes_used < MAX_SNOOZES) begin
             m_mode = 2; m_snooze_left = SNOOZE_SECS; m_snoozes_used++;
           end else begin
             m_ring_age++;
             if (tick_1hz) begin
               m_ring_ticks++;
               if (m_ring_ticks == TIMEOUT_SECS) m_mode = 3;
             end
           end
        2: if (dismiss) m_mode = 3;
           else if (tick_1hz) begin
             m_snooze_left--;
             if (m_snooze_left == 0) begin
               m_mode = 1; m_ring_age = 0; m_ring_ticks = 0;
             end
           end
        default: if (!m) m_mode = 0;
      endcase
    end
    m_prev_match = m;
  endtask

  task automatic cyc(input logic [15:0] f, input logic t, input logic e,
                     input logic d, input logic s, input logic r);
    logic [15:0] exp_leds;
    flash_in = f; tick_1hz = t; enable = e; dismiss = d; snooze = s; rst = r;
    @(posedge clk);
    #1;
    model_step();
    exp_leds = (m_mode == 1 && ((m_ring_age / BLINK_DIV) % 2 == 0)) ? 16'hFFFF : 16'h0000;
    check_val("leds", leds, exp_leds);
    check_val("ringing", {15'b0, ringing}, {15'b0, m_mode == 1});
    check_val("snoozing", {15'b0, snoozing}, {15'b0, m_mode == 2});
  endtask

  localparam logic [15:0] F = 16'hFFFF;

  initial begin
    // reset
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check_val("rst_leds", leds, 16'h0000);
    cyc(0, 0, 1, 0, 0, 0);

    // trigger and blink
    cyc(F, 0, 1, 0, 0, 0);
    check_val("s1_ring", {15'b0, ringing}, 16'h1);
    check_val("s1_leds", leds, 16'hFFFF);
    repeat (11) cyc(F, 0, 1, 0, 0, 0);

    // dismiss, no retrigger while match held, retrigger after release
    cyc(F, 0, 1, 1, 0, 0);
    check_val("s2_dis", {15'b0, ringing}, 16'h0);
    repeat (5) cyc(F, 0, 1, 0, 0, 0);
    check_val("s2_hold", {15'b0, ringing}, 16'h0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(F, 0, 1, 0, 0, 0);
    check_val("s2_rering", {15'b0, ringing}, 16'h1);

    // snooze cycles and the ignored extra snooze
    for (int k = 0; k < MAX_SNOOZES; k++) begin
      cyc(F, 0, 1, 0, 1, 0);
      check_val("s3_snz", {15'b0, snoozing}, 16'h1);
      check_val("s3_snz_leds", leds, 16'h0000);
      for (int t = 0; t < SNOOZE_SECS; t++) begin
        cyc(F, 0, 1, 0, 0, 0);
        cyc(F, 1, 1, 0, 0, 0);
      end
      check_val("s3_back", {15'b0, ringing}, 16'h1);
      check_val("s3_back_leds", leds, 16'hFFFF);
    end
    cyc(F, 0, 1, 0, 1, 0);
    check_val("s3_ignored", {15'b0, ringing}, 16'h1);

    // timeout
    for (int t = 1; t <= TIMEOUT_SECS; t++) begin
      cyc(F, 1, 1, 0, 0, 0);
      if (t < TIMEOUT_SECS) check_val("s4_still", {15'b0, ringing}, 16'h1);
      cyc(F, 0, 1, 0, 0, 0);
    end
    check_val("s4_done", {15'b0, ringing}, 16'h0);
    check_val("s4_leds", leds, 16'h0000);
    cyc(0, 0, 1, 0, 0, 0);

    // simultaneous buttons and button+tick
    cyc(F, 0, 1, 0, 0, 0);
    cyc(F, 0, 1, 1, 1, 0);
    check_val("s5_dis_snz", {14'b0, snoozing, ringing}, 16'h0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(F, 0, 1, 0, 0, 0);
    cyc(F, 1, 1, 0, 1, 0);
    check_val("s5_snz_tick", {15'b0, snoozing}, 16'h1);
    cyc(F, 1, 1, 0, 0, 0);
    cyc(F, 1, 1, 0, 0, 0);
    check_val("s5_full_snz", {15'b0, snoozing}, 16'h1);
    cyc(F, 1, 1, 0, 0, 0);
    check_val("s5_reRing", {15'b0, ringing}, 16'h1);

    // enable low and mid-ring reset
    cyc(F, 0, 1, 0, 1, 0);
    cyc(F, 0, 0, 0, 0, 0);
    check_val("s6_en", {14'b0, snoozing, ringing}, 16'h0);
    cyc(F, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(F, 0, 1, 0, 0, 0);
    cyc(F, 0, 1, 0, 0, 1);
    check_val("s6_rst", {leds[15:1], ringing}, 16'h0);
    cyc(F, 0, 1, 0, 0, 0);
    check_val("s6_after_rst", {15'b0, ringing}, 16'h1);

    // randomized phase
    begin
      logic [15:0] f;
      f = F;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 19) == 0)
          f = ($urandom_range(0, 1) == 1) ? 16'h0 : 16'(32'h1 << $urandom_range(0, 15));
        cyc(f,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 79) != 0,
            $urandom_range(0, 49) == 0,
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 299) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
